ct_fadd_close_s2_h: RTL
=======================

CT_FADD_CLOSE_S2_H -- requirements
Module: ct_fadd_close_s2_h

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for half precision.
REQ-002 The block SHALL have the port forever_cpuclk, input, 1 bit: the single clock.
REQ-003 The block SHALL have the port cpurst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have the port pipe_flush, input, 1 bit: kill all in-flight operations.
REQ-005 The block SHALL have the port s1_vld, input, 1 bit: stage-1 close-path result valid.
REQ-006 The block SHALL have the port s1_rdy, output, 1 bit: block can accept a stage-1 result.
REQ-007 The block SHALL have the port close_sum, input, 12 bits: two's-complement difference A-B; bit 11 is the sign.
REQ-008 The block SHALL have the port close_op_chg, input, 1 bit: difference negative, so the result sign flips.
REQ-009 The block SHALL have the port ff1_pred, input, 6 bits: predicted leading-one index, where 0 means bit 11 and 11 means bit 0.
REQ-010 The block SHALL have the ports close_expnt (input, 5 bits: larger operand biased exponent), close_sign (input, 1 bit: larger operand sign) and close_rm (input, 3 bits: rounding mode, where 3'b010 is RDN).
REQ-011 The block SHALL have the ports s3_vld (output, 1 bit: normalized result valid) and s3_rdy (input, 1 bit: downstream accepts the result).
REQ-012 The block SHALL have the ports close_mant (output, 11 bits: normalized significand, hidden bit at [10]) and close_guard (output, 1 bit: bit shifted below the LSB).
REQ-013 The block SHALL have the ports close_expnt_out (output, 5 bits), close_sign_out (output, 1 bit), close_zero (output, 1 bit), close_denorm (output, 1 bit) and close_pred_miss (output, 1 bit: a one-bit correction was applied).

Function
REQ-014 The block SHALL be a two-stage pipeline: register stage A (magnitude capture) followed by register stage B (normalized result); the latency from s1 handshake to s3_vld is exactly 2 cycles when there is no stall.
REQ-015 A transfer SHALL occur on any cycle where vld and rdy are both high; stage A advances when stage B is empty or stage B is draining that cycle.
REQ-016 s1_rdy SHALL equal !a_vld | a_adv, computed combinationally; stage B holds while s3_vld && !s3_rdy.
REQ-017 Stage A SHALL capture mag = close_op_chg ? (12'd0 - close_sum) : close_sum, and set sign = close_sign ^ close_op_chg.
REQ-018 Stage A SHALL capture ff1_pred, close_expnt and close_rm unchanged, and set zero = (close_sum == 0).
REQ-019 Stage B SHALL compute sh = mag << ff1_pred (12-bit), and set corr = !sh[11].
REQ-020 When corr is set, stage B SHALL shift sh left by one more bit (the prediction can only be one position early).
REQ-021 With tot = ff1_pred + corr and lim = close_expnt - 1: if tot <= lim, stage B SHALL shift by tot and set close_expnt_out = close_expnt - tot.
REQ-022 If tot > lim, or close_expnt == 0, stage B SHALL shift by lim (0 when close_expnt is 0), set close_expnt_out = 0 and set close_denorm = 1.
REQ-023 Stage B SHALL set close_mant = final_sh[11:1] and close_guard = final_sh[0].
REQ-024 close_pred_miss SHALL equal corr, qualified by a non-zero, non-denorm result.
REQ-025 When zero is set, stage B SHALL output close_mant = 0, close_expnt_out = 0, close_zero = 1 and close_sign_out = (close_rm == 3'b010).
REQ-026 ff1_pred values above 11 SHALL be treated as 11.
REQ-027 pipe_flush SHALL clear both stage valids on the next clock edge and override a simultaneous s1 handshake; data registers are don't-care.
REQ-028 With a simultaneous stage-B drain and stage-A advance, stage B SHALL load the new result in the same cycle, with no bubble.
REQ-029 Data registers SHALL load only on their stage's advance; outputs SHALL hold stable while stalled.

Reset
REQ-030 On cpurst high at a clock edge, a_vld, s3_vld and all stage-B data outputs SHALL become 0.
REQ-031 Reset SHALL dominate pipe_flush and s1_vld; s1_rdy SHALL be 1 in the cycle after reset.
REQ-032 Reset asserted mid-operation SHALL discard in-flight operations with no partial output.

Verification
REQ-033 close_sum=12'h0F0, op_chg=0, ff1_pred=4, expnt=15, s3_rdy=1 -> after 2 cycles: s3_vld=1, mant=11'h780, expnt_out=11, pred_miss=0.
REQ-034 close_sum=12'h070, ff1_pred=4, expnt=15 -> mant=11'h700, expnt_out=10, pred_miss=1.
REQ-035 close_sum=12'hF10, op_chg=1, close_sign=0, ff1_pred=4, expnt=15 -> mant=11'h780, sign_out=1, expnt_out=11.
REQ-036 close_sum=0, rm=3'b010 -> zero=1, sign_out=1, expnt_out=0; the same input with rm=3'b000 -> sign_out=0.
REQ-037 close_sum=12'h010, ff1_pred=7, expnt=3 -> shift by 2, mant=11'h020, expnt_out=0, denorm=1.
REQ-038 Stall and flush sequence:
- Issue 3 back-to-back ops with s3_rdy=0 -> s1_rdy=0 after 2 are accepted, and the outputs hold the first op.
- Then assert pipe_flush -> s3_vld=0 on the next cycle.
- Then assert cpurst mid-stream -> all valids are 0 on the next cycle.

Source files
------------

// File: rtl/ct_fadd_close_s2_h.sv
// Half-precision FADD close path, stage 2.
// Takes the close-path difference, forms its magnitude, then normalizes it
// using the predicted leading-one position, with a one-bit late correction
// and a clamp into the denormal range when the exponent runs out.
module ct_fadd_close_s2_h (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        pipe_flush,
  input  logic        s1_vld,
  output logic        s1_rdy,
  input  logic [11:0] close_sum,
  input  logic        close_op_chg,
  input  logic [5:0]  ff1_pred,
  input  logic [4:0]  close_expnt,
  input  logic        close_sign,
  input  logic [2:0]  close_rm,
  output logic        s3_vld,
  input  logic        s3_rdy,
  output logic [10:0] close_mant,
  output logic        close_guard,
  output logic [4:0]  close_expnt_out,
  output logic        close_sign_out,
  output logic        close_zero,
  output logic        close_denorm,
  output logic        close_pred_miss
);

  localparam logic [2:0] RM_RDN = 3'b010;

  // Stage A state: magnitude capture
  logic        a_vld_reg;
  logic [11:0] a_mag_reg;
  logic        a_sign_reg;
  logic [3:0]  a_pred_reg;
  logic [4:0]  a_expnt_reg;
  logic [2:0]  a_rm_reg;
  logic        a_zero_reg;

  // Stage B state: normalized result, drives the outputs directly
  logic        b_vld_reg;
  logic [10:0] b_mant_reg;
  logic        b_guard_reg;
  logic [4:0]  b_expnt_reg;
  logic        b_sign_reg;
  logic        b_zero_reg;
  logic        b_denorm_reg;
  logic        b_miss_reg;

  // Handshake
  logic b_free;
  logic a_adv;
  logic s1_fire;

  assign b_free  = !b_vld_reg || s3_rdy;
  assign a_adv   = a_vld_reg && b_free;
  assign s1_rdy  = !a_vld_reg || a_adv;
  assign s1_fire = s1_vld && s1_rdy;

  // Stage A input shaping: magnitude of the difference and a clamped prediction
  logic [11:0] a_mag_next;
  logic [3:0]  a_pred_next;

  assign a_mag_next  = close_op_chg ? (12'd0 - close_sum) : close_sum;
  assign a_pred_next = (ff1_pred > 6'd11) ? 4'd11 : ff1_pred[3:0];

  // Stage A register: capture a new operation on the input handshake
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      a_vld_reg   <= 1'b0;
      a_mag_reg   <= '0;
      a_sign_reg  <= 1'b0;
      a_pred_reg  <= '0;
      a_expnt_reg <= '0;
      a_rm_reg    <= '0;
      a_zero_reg  <= 1'b0;
    end else begin
      if (pipe_flush)   a_vld_reg <= 1'b0;
      else if (s1_fire) a_vld_reg <= 1'b1;
      else if (a_adv)   a_vld_reg <= 1'b0;
      if (s1_fire) begin
        a_mag_reg   <= a_mag_next;
        a_sign_reg  <= close_sign ^ close_op_chg;
        a_pred_reg  <= a_pred_next;
        a_expnt_reg <= close_expnt;
        a_rm_reg    <= close_rm;
        a_zero_reg  <= (close_sum == 12'd0);
      end
    end
  end

  // Stage B normalization datapath
  logic [11:0] pre_sh;
  logic        corr;
  logic [4:0]  tot;
  logic [4:0]  lim;
  logic        expnt_nz;
  logic        norm_ok;
  logic [4:0]  shamt;
  logic [11:0] fin_sh;

  assign pre_sh   = a_mag_reg << a_pred_reg;
  // The predictor may be one position early; never late.
  assign corr     = !pre_sh[11];
  assign tot      = {1'b0, a_pred_reg} + {4'd0, corr};
  assign lim      = a_expnt_reg - 5'd1;
  assign expnt_nz = (a_expnt_reg != 5'd0);
  // Full normalization is only possible while the exponent stays at least 1.
  assign norm_ok  = expnt_nz && (tot <= lim);
  assign shamt    = norm_ok ? tot : (expnt_nz ? lim : 5'd0);
  assign fin_sh   = a_mag_reg << shamt;

  logic [10:0] b_mant_next;
  logic        b_guard_next;
  logic [4:0]  b_expnt_next;
  logic        b_sign_next;
  logic        b_denorm_next;
  logic        b_miss_next;

  // Stage B result selection, with the exact-zero case overriding everything
  always_comb begin
    b_mant_next   = fin_sh[11:1];
    b_guard_next  = fin_sh[0];
    b_expnt_next  = norm_ok ? (a_expnt_reg - tot) : 5'd0;
    b_sign_next   = a_sign_reg;
    b_denorm_next = !norm_ok;
    b_miss_next   = corr && norm_ok;
    if (a_zero_reg) begin
      b_mant_next   = '0;
      b_guard_next  = 1'b0;
      b_expnt_next  = '0;
      b_sign_next   = (a_rm_reg == RM_RDN);
      b_denorm_next = 1'b0;
      b_miss_next   = 1'b0;
    end
  end

  // Stage B register: load on stage-A advance, hold while the consumer stalls
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      b_vld_reg    <= 1'b0;
      b_mant_reg   <= '0;
      b_guard_reg  <= 1'b0;
      b_expnt_reg  <= '0;
      b_sign_reg   <= 1'b0;
      b_zero_reg   <= 1'b0;
      b_denorm_reg <= 1'b0;
      b_miss_reg   <= 1'b0;
    end else begin
      if (pipe_flush)  b_vld_reg <= 1'b0;
      else if (b_free) b_vld_reg <= a_vld_reg;
      if (a_adv) begin
        b_mant_reg   <= b_mant_next;
        b_guard_reg  <= b_guard_next;
        b_expnt_reg  <= b_expnt_next;
        b_sign_reg   <= b_sign_next;
        b_zero_reg   <= a_zero_reg;
        b_denorm_reg <= b_denorm_next;
        b_miss_reg   <= b_miss_next;
      end
    end
  end

  assign s3_vld          = b_vld_reg;
  assign close_mant      = b_mant_reg;
  assign close_guard     = b_guard_reg;
  assign close_expnt_out = b_expnt_reg;
  assign close_sign_out  = b_sign_reg;
  assign close_zero      = b_zero_reg;
  assign close_denorm    = b_denorm_reg;
  assign close_pred_miss = b_miss_reg;

endmodule
